rv_ctrl_pipe: RTL and testbench
===============================

Name: rv_ctrl_pipe

Overview:
Pipelined main control unit for the 5-stage RV32I core. Decodes the full RV32I base opcode set in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, which raise a stall and insert a bubble. Generates operand-forwarding selects for the EX-stage datapath.

Parameters:
RF_AW, 5, register-file address width (rd/rs1/rs2 fields).
X0_ZERO, 1, 1: rd==0 suppresses reg_write and never matches for hazard or forwarding; 0: x0 treated as an ordinary register.

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  reset, asynchronous, active-low
id_valid_i  in  1  ID-stage instruction is valid
id_instr_i  in  32  ID-stage instruction word; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20]
flush_i  in  1  kill younger instruction (taken branch/jump resolved in EX)
stall_o  out  1  hold PC and IF/ID this cycle (combinational)
ex_ctrl_o  out  9  {reg_write, alu_src, mem_read, mem_write, branch, jump, wb_sel[1:0], illegal}
ex_alu_op_o  out  2  00 add, 01 branch-compare, 10 R-funct, 11 I-funct
ex_rd_o, ex_rs1_o, ex_rs2_o  out  RF_AW  EX-stage register indices
fwd_a_o, fwd_b_o  out  2  00 regfile, 10 EX/MEM result, 01 MEM/WB result
mem_reg_write_o, mem_read_o, mem_write_o  out  1  MEM-stage controls
mem_rd_o  out  RF_AW  MEM-stage rd
wb_reg_write_o  out  1  WB-stage write enable
wb_sel_o  out  2  00 ALU, 01 memory, 10 PC+4
wb_rd_o  out  RF_AW  WB-stage rd

Behaviour:
- Decode (combinational, ID) sets reg_write / alu_src / mem_read / mem_write / branch / jump / wb_sel / alu_op / illegal:
  - R 0110011: 1/0/0/0/0/0/00/10/0
  - OP-IMM 0010011: 1/1/0/0/0/0/00/11/0
  - LOAD 0000011: 1/1/1/0/0/0/01/00/0
  - STORE 0100011: 0/1/0/1/0/0/00/00/0
  - BRANCH 1100011: 0/0/0/0/1/0/00/01/0
  - JAL 1101111 and JALR 1100111: 1/1/0/0/0/1/10/00/0
  - LUI 0110111 and AUIPC 0010111: 1/1/0/0/0/0/00/00/0
  - any other opcode: all zero, illegal=1
  - id_valid_i=0: all zero, illegal=0.
- Source use: rs1 is used by all classes except LUI, AUIPC and JAL. rs2 is used by R, STORE and BRANCH only.
- With X0_ZERO=1: decoded reg_write is forced to 0 when rd==0.
- Load-use hazard: ex mem_read=1 and ex_rd matches a used ID source (nonzero when X0_ZERO=1) and id_valid_i=1 -> stall_o=1.
- stall_o is gated by !flush_i. flush_i has priority over stall.
- ID/EX register: on each edge it loads a bubble (all-zero bundle and indices) if flush_i or stall_o, else the decoded bundle.
- EX/MEM and MEM/WB advance unconditionally every cycle.
- Forwarding (combinational on EX): fwd_a=10 if mem_reg_write and mem_rd==ex_rs1 (mem_rd nonzero when X0_ZERO=1); else 01 if the same holds for the WB stage; else 00. fwd_b is identical using ex_rs2. EX/MEM has priority over MEM/WB.
- Latency: decode to ex_* = 1 clk, to mem_* = 2, to wb_* = 3.
- Regfile is write-first, so WB->ID needs no stall or forward.
- Reset: all pipeline registers clear immediately on rstn low. All registered outputs read 0; stall_o=0 and fwd_*=00 follow from the cleared state. Reset mid-stall discards the stalled instruction.

Optional Feature:
RV_CTRL_FWD_EN
- Defined: forwarding as above; stall only on load-use.
- Undefined: fwd_a_o and fwd_b_o are tied to 00. stall_o is asserted for any used ID source matching rd of an EX or MEM stage with reg_write=1, under the same x0 and flush gating. A dependent ALU instruction immediately behind its producer stalls for 2 cycles.

Test Plan:
- add x3,x1,x2 valid -> after 1 clk ex_ctrl reg_write=1, alu_src=0, ex_alu_op_o=10, ex_rd_o=3 -> clk 2 mem_reg_write_o=1, mem_rd_o=3 -> clk 3 wb_reg_write_o=1, wb_sel_o=00.
- lw x5,0(x1) then add x6,x5,x1 (FWD_EN) -> stall_o=1 for exactly 1 cycle; EX holds a bubble; when add reaches EX, fwd_a_o=01 and fwd_b_o=00.
- addi x7,x0,5 then sub x8,x7,x7 (FWD_EN) -> no stall; sub in EX gives fwd_a_o=fwd_b_o=10. With the macro undefined: stall_o=1 for 2 cycles, fwd outputs 00.
- lw x5 in EX, dependent add in ID, flush_i=1 same cycle -> stall_o=0; next clk EX bundle all zero.
- opcode 7'b1111111 valid -> ex illegal=1 and all other ctrl bits 0. addi x0,x0,0 -> ex reg_write=0.
- rstn low mid-stream (load in MEM, stall active) -> all outputs 0 before the next clk edge, stall_o=0. After release, first instruction appears in EX after 1 clk.

Source files
------------

// File: rtl/rv_ctrl_pipe.sv
// Pipelined main control for the 5-stage RV32I core: ID decode, ID/EX-EX/MEM-MEM/WB control pipe,
// load-use / RAW stall and EX operand-forwarding selects. Optional macro: RV_CTRL_FWD_EN.
module rv_ctrl_pipe #(
    parameter int RF_AW   = 5,
    parameter bit X0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid_i,
    input  logic [31:0]      id_instr_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [8:0]       ex_ctrl_o,
    output logic [1:0]       ex_alu_op_o,
    output logic [RF_AW-1:0] ex_rd_o,
    output logic [RF_AW-1:0] ex_rs1_o,
    output logic [RF_AW-1:0] ex_rs2_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [RF_AW-1:0] mem_rd_o,
    output logic             wb_reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic [RF_AW-1:0] wb_rd_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Register equality that ignores x0 when it is hard-wired zero.
    function automatic logic reg_match(input logic [RF_AW-1:0] a, input logic [RF_AW-1:0] b);
        return (a == b) && ((X0_ZERO == 1'b0) || (a != {RF_AW{1'b0}}));
    endfunction

    logic [6:0]       w_opcode;
    logic [RF_AW-1:0] w_id_rd;
    logic [RF_AW-1:0] w_id_rs1;
    logic [RF_AW-1:0] w_id_rs2;
    logic [8:0]       w_dec_raw;
    logic [8:0]       w_dec_ctrl;
    logic [1:0]       w_dec_alu_op;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic             w_rd_is_x0;
    logic             w_hazard;
    logic             w_stall;
    logic             w_unused_funct;

    logic [8:0]       r_ex_ctrl;
    logic [1:0]       r_ex_alu_op;
    logic [RF_AW-1:0] r_ex_rd;
    logic [RF_AW-1:0] r_ex_rs1;
    logic [RF_AW-1:0] r_ex_rs2;
    logic             r_mem_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [1:0]       r_mem_wb_sel;
    logic [RF_AW-1:0] r_mem_rd;
    logic             r_wb_reg_write;
    logic [1:0]       r_wb_sel;
    logic [RF_AW-1:0] r_wb_rd;

    assign w_opcode       = id_instr_i[6:0];
    assign w_id_rd        = id_instr_i[7 +: RF_AW];
    assign w_id_rs1       = id_instr_i[15 +: RF_AW];
    assign w_id_rs2       = id_instr_i[20 +: RF_AW];
    assign w_unused_funct = ^{id_instr_i[31:25], id_instr_i[14:12]};

    // ID decode: bundle is {reg_write, alu_src, mem_read, mem_write, branch, jump, wb_sel, illegal}.
    always_comb begin
        w_dec_raw    = 9'b000000000;
        w_dec_alu_op = 2'b00;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        if (id_valid_i) begin
            case (w_opcode)
                OP_R: begin
                    w_dec_raw = 9'b100000000; w_dec_alu_op = 2'b10;
                    w_use_rs1 = 1'b1;         w_use_rs2    = 1'b1;
                end
                OP_IMM: begin
                    w_dec_raw = 9'b110000000; w_dec_alu_op = 2'b11; w_use_rs1 = 1'b1;
                end
                OP_LOAD: begin
                    w_dec_raw = 9'b111000010; w_use_rs1 = 1'b1;
                end
                OP_STORE: begin
                    w_dec_raw = 9'b010100000;
                    w_use_rs1 = 1'b1;         w_use_rs2 = 1'b1;
                end
                OP_BRANCH: begin
                    w_dec_raw = 9'b000010000; w_dec_alu_op = 2'b01;
                    w_use_rs1 = 1'b1;         w_use_rs2    = 1'b1;
                end
                OP_JAL:   w_dec_raw = 9'b110001100;
                OP_JALR: begin
                    w_dec_raw = 9'b110001100; w_use_rs1 = 1'b1;
                end
                OP_LUI:   w_dec_raw = 9'b110000000;
                OP_AUIPC: w_dec_raw = 9'b110000000;
                default:  w_dec_raw = 9'b000000001;
            endcase
        end else begin
            w_dec_raw = 9'b000000000;
        end
    end

    assign w_rd_is_x0 = (X0_ZERO == 1'b1) && (w_id_rd == {RF_AW{1'b0}});
    assign w_dec_ctrl = {w_dec_raw[8] & ~w_rd_is_x0, w_dec_raw[7:0]};

`ifdef RV_CTRL_FWD_EN
    assign w_hazard = r_ex_ctrl[6] &&
                      ((w_use_rs1 && reg_match(r_ex_rd, w_id_rs1)) ||
                       (w_use_rs2 && reg_match(r_ex_rd, w_id_rs2)));

    // Forward select for operand A: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        if (r_mem_reg_write && reg_match(r_mem_rd, r_ex_rs1)) begin
            fwd_a_o = 2'b10;
        end else if (r_wb_reg_write && reg_match(r_wb_rd, r_ex_rs1)) begin
            fwd_a_o = 2'b01;
        end else begin
            fwd_a_o = 2'b00;
        end
    end

    // Forward select for operand B, same priority as operand A.
    always_comb begin
        if (r_mem_reg_write && reg_match(r_mem_rd, r_ex_rs2)) begin
            fwd_b_o = 2'b10;
        end else if (r_wb_reg_write && reg_match(r_wb_rd, r_ex_rs2)) begin
            fwd_b_o = 2'b01;
        end else begin
            fwd_b_o = 2'b00;
        end
    end
`else
    // Without forwarding, any pending producer in EX or MEM must drain first.
    assign w_hazard = (r_ex_ctrl[8] &&
                       ((w_use_rs1 && reg_match(r_ex_rd, w_id_rs1)) ||
                        (w_use_rs2 && reg_match(r_ex_rd, w_id_rs2)))) ||
                      (r_mem_reg_write &&
                       ((w_use_rs1 && reg_match(r_mem_rd, w_id_rs1)) ||
                        (w_use_rs2 && reg_match(r_mem_rd, w_id_rs2))));
    assign fwd_a_o  = 2'b00;
    assign fwd_b_o  = 2'b00;
`endif

    assign w_stall = w_hazard & id_valid_i & ~flush_i;
    assign stall_o = w_stall;

    // ID/EX register: bubble on flush or stall, otherwise take the decoded bundle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_ctrl   <= 9'b000000000;
            r_ex_alu_op <= 2'b00;
            r_ex_rd     <= {RF_AW{1'b0}};
            r_ex_rs1    <= {RF_AW{1'b0}};
            r_ex_rs2    <= {RF_AW{1'b0}};
        end else if (flush_i || w_stall) begin
            r_ex_ctrl   <= 9'b000000000;
            r_ex_alu_op <= 2'b00;
            r_ex_rd     <= {RF_AW{1'b0}};
            r_ex_rs1    <= {RF_AW{1'b0}};
            r_ex_rs2    <= {RF_AW{1'b0}};
        end else begin
            r_ex_ctrl   <= w_dec_ctrl;
            r_ex_alu_op <= w_dec_alu_op;
            r_ex_rd     <= w_id_rd;
            r_ex_rs1    <= w_id_rs1;
            r_ex_rs2    <= w_id_rs2;
        end
    end

    // EX/MEM and MEM/WB registers advance every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_reg_write <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_wb_sel    <= 2'b00;
            r_mem_rd        <= {RF_AW{1'b0}};
            r_wb_reg_write  <= 1'b0;
            r_wb_sel        <= 2'b00;
            r_wb_rd         <= {RF_AW{1'b0}};
        end else begin
            r_mem_reg_write <= r_ex_ctrl[8];
            r_mem_read      <= r_ex_ctrl[6];
            r_mem_write     <= r_ex_ctrl[5];
            r_mem_wb_sel    <= r_ex_ctrl[2:1];
            r_mem_rd        <= r_ex_rd;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_sel        <= r_mem_wb_sel;
            r_wb_rd         <= r_mem_rd;
        end
    end

    assign ex_ctrl_o       = r_ex_ctrl;
    assign ex_alu_op_o     = r_ex_alu_op;
    assign ex_rd_o         = r_ex_rd;
    assign ex_rs1_o        = r_ex_rs1;
    assign ex_rs2_o        = r_ex_rs2;
    assign mem_reg_write_o = r_mem_reg_write;
    assign mem_read_o      = r_mem_read;
    assign mem_write_o     = r_mem_write;
    assign mem_rd_o        = r_mem_rd;
    assign wb_reg_write_o  = r_wb_reg_write;
    assign wb_sel_o        = r_wb_sel;
    assign wb_rd_o         = r_wb_rd;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// Directed self-checking bench for rv_ctrl_pipe; expectations follow RV_CTRL_FWD_EN when defined.
module tb_rv_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid_i;
    logic [31:0] id_instr_i;
    logic        flush_i;
    logic        stall_o;
    logic [8:0]  ex_ctrl_o;
    logic [1:0]  ex_alu_op_o;
    logic [4:0]  ex_rd_o, ex_rs1_o, ex_rs2_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        mem_reg_write_o, mem_read_o, mem_write_o;
    logic [4:0]  mem_rd_o;
    logic        wb_reg_write_o;
    logic [1:0]  wb_sel_o;
    logic [4:0]  wb_rd_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADD3   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_LW5_X1 = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] I_LW5_X0 = {12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] I_LW13   = {12'd0, 5'd0, 3'b010, 5'd13, 7'b0000011};
    localparam logic [31:0] I_ADD6   = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] I_ADDI7  = {12'd5, 5'd0, 3'b000, 5'd7, 7'b0010011};
    localparam logic [31:0] I_SUB8   = {7'b0100000, 5'd7, 5'd7, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] I_ADDI14 = {12'd1, 5'd0, 3'b000, 5'd14, 7'b0010011};

    logic [31:0] tv_instr [0:8];
    logic        tv_valid [0:8];
    logic [8:0]  tv_ctrl  [0:8];
    logic [1:0]  tv_aluop [0:8];

    always #5 clk = ~clk;

    rv_ctrl_pipe dut (
        .clk(clk), .rstn(rstn), .id_valid_i(id_valid_i), .id_instr_i(id_instr_i),
        .flush_i(flush_i), .stall_o(stall_o), .ex_ctrl_o(ex_ctrl_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .mem_reg_write_o(mem_reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_rd_o(mem_rd_o), .wb_reg_write_o(wb_reg_write_o), .wb_sel_o(wb_sel_o), .wb_rd_o(wb_rd_o)
    );

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins);
        id_valid_i = v;
        id_instr_i = ins;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_ex_ctrl"}, {23'd0, ex_ctrl_o}, 32'd0);
        chk_val({tag, "_ex_rd"}, {27'd0, ex_rd_o}, 32'd0);
        chk_val({tag, "_mem"}, {27'd0, mem_reg_write_o, mem_read_o, mem_write_o, 2'b00}, 32'd0);
        chk_val({tag, "_mem_rd"}, {27'd0, mem_rd_o}, 32'd0);
        chk_val({tag, "_wb"}, {22'd0, wb_reg_write_o, wb_sel_o, wb_rd_o}, 32'd0);
        chk_val({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk_val({tag, "_fwd"}, {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
    endtask

    initial begin
        tv_instr[0] = 32'h0000007F;                                        tv_valid[0] = 1'b1;
        tv_ctrl[0]  = 9'b000000001;                                        tv_aluop[0] = 2'b00;
        tv_instr[1] = 32'h00000013;                                        tv_valid[1] = 1'b1;
        tv_ctrl[1]  = 9'b010000000;                                        tv_aluop[1] = 2'b11;
        tv_instr[2] = {7'd0, 5'd2, 5'd0, 3'b010, 5'd0, 7'b0100011};         tv_valid[2] = 1'b1;
        tv_ctrl[2]  = 9'b010100000;                                        tv_aluop[2] = 2'b00;
        tv_instr[3] = {7'd0, 5'd0, 5'd0, 3'b000, 5'd0, 7'b1100011};         tv_valid[3] = 1'b1;
        tv_ctrl[3]  = 9'b000010000;                                        tv_aluop[3] = 2'b01;
        tv_instr[4] = {20'h12345, 5'd9, 7'b0110111};                       tv_valid[4] = 1'b1;
        tv_ctrl[4]  = 9'b110000000;                                        tv_aluop[4] = 2'b00;
        tv_instr[5] = {20'h00001, 5'd10, 7'b0010111};                      tv_valid[5] = 1'b1;
        tv_ctrl[5]  = 9'b110000000;                                        tv_aluop[5] = 2'b00;
        tv_instr[6] = {12'd0, 5'd0, 3'b000, 5'd11, 7'b1100111};            tv_valid[6] = 1'b1;
        tv_ctrl[6]  = 9'b110001100;                                        tv_aluop[6] = 2'b00;
        tv_instr[7] = {20'h00000, 5'd12, 7'b1101111};                      tv_valid[7] = 1'b1;
        tv_ctrl[7]  = 9'b110001100;                                        tv_aluop[7] = 2'b00;
        tv_instr[8] = I_ADD3;                                              tv_valid[8] = 1'b0;
        tv_ctrl[8]  = 9'b000000000;                                        tv_aluop[8] = 2'b00;

        rstn = 1'b0; id_valid_i = 1'b0; id_instr_i = 32'd0; flush_i = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        rstn = 1'b1;

        // add x3,x1,x2 down the pipe
        drive(1'b1, I_ADD3);
        chk_val("add_stall", {31'd0, stall_o}, 32'd0);
        tick();
        drive(1'b0, 32'd0);
        chk_val("add_ex_ctrl", {23'd0, ex_ctrl_o}, 32'h100);
        chk_val("add_ex_aluop", {30'd0, ex_alu_op_o}, 32'd2);
        chk_val("add_ex_regs", {17'd0, ex_rd_o, ex_rs1_o, ex_rs2_o}, {17'd0, 5'd3, 5'd1, 5'd2});
        tick();
        chk_val("add_mem", {26'd0, mem_reg_write_o, mem_rd_o}, {26'd0, 1'b1, 5'd3});
        chk_val("add_ex_bubble", {23'd0, ex_ctrl_o}, 32'd0);
        tick();
        chk_val("add_wb", {24'd0, wb_reg_write_o, wb_sel_o, wb_rd_o}, {24'd0, 1'b1, 2'b00, 5'd3});

        // lw x5,0(x1) ; add x6,x5,x1
        drive(1'b1, I_LW5_X1);
        chk_val("lw_stall0", {31'd0, stall_o}, 32'd0);
        tick();
        chk_val("lw_ex_ctrl", {23'd0, ex_ctrl_o}, {23'd0, 9'b111000010});
        chk_val("lw_ex_rd", {27'd0, ex_rd_o}, 32'd5);
        drive(1'b1, I_ADD6);
        chk_val("lu_stall1", {31'd0, stall_o}, 32'd1);
        tick();
        chk_val("lu_ex_bubble", {23'd0, ex_ctrl_o}, 32'd0);
        chk_val("lu_mem", {26'd0, mem_read_o, mem_rd_o}, {26'd0, 1'b1, 5'd5});
`ifdef RV_CTRL_FWD_EN
        chk_val("lu_stall2", {31'd0, stall_o}, 32'd0);
`else
        chk_val("lu_stall2", {31'd0, stall_o}, 32'd1);
        tick();
        chk_val("lu_ex_bubble2", {23'd0, ex_ctrl_o}, 32'd0);
        chk_val("lu_stall3", {31'd0, stall_o}, 32'd0);
`endif
        tick();
        drive(1'b0, 32'd0);
        chk_val("lu_ex_rd", {27'd0, ex_rd_o}, 32'd6);
`ifdef RV_CTRL_FWD_EN
        chk_val("lu_fwd", {28'd0, fwd_a_o, fwd_b_o}, {28'd0, 2'b01, 2'b00});
`else
        chk_val("lu_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
`endif

        // addi x7,x0,5 ; sub x8,x7,x7
        drive(1'b1, I_ADDI7);
        chk_val("raw_stall0", {31'd0, stall_o}, 32'd0);
        tick();
        drive(1'b1, I_SUB8);
`ifdef RV_CTRL_FWD_EN
        chk_val("raw_stall1", {31'd0, stall_o}, 32'd0);
`else
        chk_val("raw_stall1", {31'd0, stall_o}, 32'd1);
        tick();
        chk_val("raw_stall2", {31'd0, stall_o}, 32'd1);
        tick();
        chk_val("raw_stall3", {31'd0, stall_o}, 32'd0);
`endif
        tick();
        drive(1'b0, 32'd0);
        chk_val("raw_ex", {25'd0, ex_rd_o, ex_alu_op_o}, {25'd0, 5'd8, 2'b10});
`ifdef RV_CTRL_FWD_EN
        chk_val("raw_fwd", {28'd0, fwd_a_o, fwd_b_o}, {28'd0, 2'b10, 2'b10});
`else
        chk_val("raw_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
`endif

        // load in EX, dependent in ID, flush wins
        drive(1'b1, I_LW5_X1);
        tick();
        flush_i = 1'b1;
        drive(1'b1, I_ADD6);
        chk_val("flush_stall", {31'd0, stall_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'd0);
        chk_val("flush_ex", {13'd0, ex_ctrl_o, ex_rd_o, ex_alu_op_o}, 32'd0);

        // decode table
        for (int i = 0; i < 9; i++) begin
            drive(tv_valid[i], tv_instr[i]);
            chk_val($sformatf("dec%0d_stall", i), {31'd0, stall_o}, 32'd0);
            tick();
            chk_val($sformatf("dec%0d_ctrl", i), {23'd0, ex_ctrl_o}, {23'd0, tv_ctrl[i]});
            chk_val($sformatf("dec%0d_aluop", i), {30'd0, ex_alu_op_o}, {30'd0, tv_aluop[i]});
        end

        // asynchronous reset with a load in MEM and a stall pending
        drive(1'b1, I_LW13);
        tick();
        drive(1'b1, I_LW5_X0);
        tick();
        drive(1'b1, I_ADD6);
        chk_val("rst_pre_stall", {31'd0, stall_o}, 32'd1);
        chk_val("rst_pre_mem", {26'd0, mem_read_o, mem_rd_o}, {26'd0, 1'b1, 5'd13});
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        rstn = 1'b1;
        drive(1'b1, I_ADDI14);
        tick();
        drive(1'b0, 32'd0);
        chk_val("rst_post_ex", {16'd0, ex_ctrl_o, ex_rd_o, ex_alu_op_o},
                {16'd0, 9'b110000000, 5'd14, 2'b11});
        chk_val("rst_post_mem", {26'd0, mem_reg_write_o, mem_rd_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
